// File: rtl/cluster_box_encoder_if.sv
// Stream bundle between the segment refiner, the box encoder and the fusion stage.
// The master drives records in and accepts boxes out; the encoder is the slave.
interface cluster_box_encoder_if;
    logic         in_valid;
    logic [75:0]  in_data;
    logic         frame_done;
    logic         out_valid;
    logic         out_ready;
    logic [113:0] out_box;
    logic         out_last;
    logic         out_empty;
    logic [12:0]  frame_box_count;
    logic [15:0]  overflow_count;
    logic [15:0]  reject_count;

    modport master (
        output in_valid, in_data, frame_done, out_ready,
        input  out_valid, out_box, out_last, out_empty,
        input  frame_box_count, overflow_count, reject_count
    );

    modport slave (
        input  in_valid, in_data, frame_done, out_ready,
        output out_valid, out_box, out_last, out_empty,
        output frame_box_count, overflow_count, reject_count
    );
endinterface

// File: rtl/cluster_box_encoder.sv
// Buffers packed cluster records and converts each into an object-proposal box
// (centre, extent, volume, size class) on a valid/ready stream with in-band frame markers.
module cluster_box_encoder #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned SMALL_DIM  = 8,
    parameter int unsigned MED_DIM    = 64
) (
    input logic                  clk,
    input logic                  rst,
    cluster_box_encoder_if.slave bus
);
    localparam int unsigned    PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned    GEOM_W  = 79;
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [10:0]    SMALL_L = 11'(SMALL_DIM);
    localparam logic [10:0]    MED_L   = 11'(MED_DIM);
    localparam logic [12:0]    RUN_MAX = 13'd4095;
    localparam logic [15:0]    CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic        marker;
        logic        last;
        logic [75:0] data;
    } entry_t;

    entry_t           fifo_mem [FIFO_DEPTH];
    entry_t           push_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic             push_req;
    logic             do_push;
    logic             do_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;
    logic             stall;
    logic             accept;

    // geom = {size16, cx10, cy10, cz10, dx11, dy11, dz11}
    logic              s1_valid, s1_marker, s1_last;
    logic [GEOM_W-1:0] s1_geom;
    logic              s2_valid, s2_marker, s2_last;
    logic [GEOM_W-1:0] s2_geom;
    logic [21:0]       s2_dxdy;
    logic [10:0]       s2_dmax;
    logic              s3_valid, s3_marker, s3_last;
    logic [GEOM_W-1:0] s3_geom;
    logic [32:0]       s3_vol;
    logic [1:0]        s3_class;

    logic              out_valid_q, out_last_q, out_empty_q;
    logic [113:0]      out_box_q;
    logic [12:0]       run_cnt;
    logic [12:0]       run_next;
    logic [12:0]       frame_cnt;
    logic [15:0]       ovf_cnt;
    logic [15:0]       rej_cnt;

    // Decode signals from the FIFO head
    logic [9:0]        mn_x, mx_x, mn_y, mx_y, mn_z, mx_z;
    logic [10:0]       d_x, d_y, d_z;
    logic [9:0]        c_x, c_y, c_z;
    logic              bad;
    logic [GEOM_W-1:0] dec_geom;
    logic [10:0]       m_xy;
    logic [10:0]       dmax;

    assign stall      = out_valid_q && !bus.out_ready;
    assign accept     = out_valid_q && bus.out_ready;
    assign fifo_full  = (fifo_cnt == DEPTH_L);
    assign fifo_empty = (fifo_cnt == '0);
    assign head       = fifo_mem[rd_ptr];

    // A record and frame_done in the same cycle share one entry; frame_done alone is a marker.
    assign push_req   = bus.in_valid || bus.frame_done;
    assign push_entry = bus.in_valid ? entry_t'{marker: 1'b0, last: bus.frame_done,
                                                data: bus.in_data}
                                     : entry_t'{marker: 1'b1, last: 1'b1, data: '0};
    assign do_pop     = !fifo_empty && !stall;
    assign do_push    = push_req && (!fifo_full || do_pop);
    assign drop       = push_req && fifo_full && !do_pop;

    always_comb begin
        {mn_x, mx_x, mn_y, mx_y, mn_z, mx_z} = head.data[59:0];
        d_x = {1'b0, mx_x} - {1'b0, mn_x} + 11'd1;
        d_y = {1'b0, mx_y} - {1'b0, mn_y} + 11'd1;
        d_z = {1'b0, mx_z} - {1'b0, mn_z} + 11'd1;
        c_x = 10'(({1'b0, mn_x} + {1'b0, mx_x}) >> 1);
        c_y = 10'(({1'b0, mn_y} + {1'b0, mx_y}) >> 1);
        c_z = 10'(({1'b0, mn_z} + {1'b0, mx_z}) >> 1);
        bad = (mn_x > mx_x) || (mn_y > mx_y) || (mn_z > mx_z);
        if (head.marker || bad) begin
            dec_geom = '0;
        end else begin
            dec_geom = {head.data[75:60], c_x, c_y, c_z, d_x, d_y, d_z};
        end
    end

    always_comb begin
        m_xy = (s1_geom[32:22] > s1_geom[21:11]) ? s1_geom[32:22] : s1_geom[21:11];
        dmax = (m_xy > s1_geom[10:0]) ? m_xy : s1_geom[10:0];
    end

    assign run_next = (!out_empty_q && run_cnt != RUN_MAX) ? run_cnt + 13'd1 : run_cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            s1_valid    <= 1'b0;
            s1_marker   <= 1'b0;
            s1_last     <= 1'b0;
            s1_geom     <= '0;
            s2_valid    <= 1'b0;
            s2_marker   <= 1'b0;
            s2_last     <= 1'b0;
            s2_geom     <= '0;
            s2_dxdy     <= '0;
            s2_dmax     <= '0;
            s3_valid    <= 1'b0;
            s3_marker   <= 1'b0;
            s3_last     <= 1'b0;
            s3_geom     <= '0;
            s3_vol      <= '0;
            s3_class    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_empty_q <= 1'b0;
            out_box_q   <= '0;
            run_cnt     <= '0;
            frame_cnt   <= '0;
            ovf_cnt     <= '0;
            rej_cnt     <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (drop && ovf_cnt != CNT_MAX) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
            if (do_pop && bad && rej_cnt != CNT_MAX) begin
                rej_cnt <= rej_cnt + 16'd1;
            end

            if (!stall) begin
                // A rejected record survives only as a marker when it closes the frame.
                s1_valid    <= do_pop && (!bad || head.last);
                s1_marker   <= head.marker || bad;
                s1_last     <= head.last;
                s1_geom     <= dec_geom;

                s2_valid    <= s1_valid;
                s2_marker   <= s1_marker;
                s2_last     <= s1_last;
                s2_geom     <= s1_geom;
                s2_dxdy     <= 22'(s1_geom[32:22]) * 22'(s1_geom[21:11]);
                s2_dmax     <= dmax;

                s3_valid    <= s2_valid;
                s3_marker   <= s2_marker;
                s3_last     <= s2_last;
                s3_geom     <= s2_geom;
                s3_vol      <= 33'(s2_dxdy) * 33'(s2_geom[10:0]);
                s3_class    <= (s2_dmax <= SMALL_L) ? 2'd0 :
                               (s2_dmax <= MED_L)   ? 2'd1 : 2'd2;

                out_valid_q <= s3_valid;
                out_last_q  <= s3_last;
                out_empty_q <= s3_marker;
                out_box_q   <= s3_marker ? '0 : {s3_vol, s3_geom, s3_class};
            end

            if (accept) begin
                if (out_last_q) begin
                    frame_cnt <= run_next;
                    run_cnt   <= '0;
                end else begin
                    run_cnt   <= run_next;
                end
            end
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.out_box         = out_box_q;
    assign bus.out_last        = out_last_q;
    assign bus.out_empty       = out_empty_q;
    assign bus.frame_box_count = frame_cnt;
    assign bus.overflow_count  = ovf_cnt;
    assign bus.reject_count    = rej_cnt;
endmodule

// File: tb/tb_cluster_box_encoder.sv
// Scoreboard bench for cluster_box_encoder: directed records push expected beats into a queue,
// a negedge monitor pops and compares every accepted output beat.
module tb_cluster_box_encoder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cluster_box_encoder_if bus ();
    cluster_box_encoder dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [113:0] box;
        logic         last;
        logic         empty;
    } beat_t;

    beat_t exp_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic logic [75:0] mk_rec(input logic [15:0] size, input logic [9:0] x0, x1,
                                           y0, y1, z0, z1);
        return {size, x0, x1, y0, y1, z0, z1};
    endfunction

    function automatic logic [113:0] mk_box(input logic [32:0] vol, input logic [15:0] size,
                                            input logic [9:0] cx, cy, cz,
                                            input logic [10:0] dx, dy, dz,
                                            input logic [1:0] cls);
        return {vol, size, cx, cy, cz, dx, dy, dz, cls};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_box(input logic [113:0] box);
        exp_q.push_back('{box: box, last: 1'b0, empty: 1'b0});
    endtask

    task automatic exp_marker();
        exp_q.push_back('{box: '0, last: 1'b1, empty: 1'b1});
    endtask

    task automatic push_rec(input logic [75:0] rec, input logic fd);
        bus.in_valid   = 1'b1;
        bus.in_data    = rec;
        bus.frame_done = fd;
        cycle();
        bus.in_valid   = 1'b0;
        bus.frame_done = 1'b0;
    endtask

    task automatic push_fd();
        bus.frame_done = 1'b1;
        cycle();
        bus.frame_done = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            cycle();
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        repeat (2) cycle();
    endtask

    // Monitor: every beat the sink accepts is compared against the head of the queue.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_beat: got box=%h last=%b empty=%b, required no beat",
                         bus.out_box, bus.out_last, bus.out_empty);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_box !== e.box || bus.out_last !== e.last || bus.out_empty !== e.empty)
                begin
                    n_bad++;
                    $display("FAIL beat: got box=%h last=%b empty=%b, required box=%h last=%b empty=%b",
                             bus.out_box, bus.out_last, bus.out_empty, e.box, e.last, e.empty);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.frame_done = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_box_nz", 32'(|bus.out_box), 0);
        check("rst_frame_box_count", bus.frame_box_count, 0);
        check("rst_overflow_count", bus.overflow_count, 0);
        check("rst_reject_count", bus.reject_count, 0);
        rst = 1'b0;
        cycle();

        // Basic record and exact latency
        exp_box(mk_box(33'd16, 16'd20, 10'd11, 10'd0, 10'd6, 11'd4, 11'd1, 11'd4, 2'd0));
        push_rec(mk_rec(16'd20, 10'd10, 10'd13, 10'd0, 10'd0, 10'd5, 10'd8), 1'b0);
        repeat (3) cycle();
        check("latency_n3_valid", bus.out_valid, 0);
        cycle();
        check("latency_n4_valid", bus.out_valid, 1);
        drain("t1");

        // Full-range record and class boundaries, back to back
        exp_box(mk_box(33'h0_4000_0000, 16'hABCD, 10'd511, 10'd511, 10'd511,
                       11'd1024, 11'd1024, 11'd1024, 2'd2));
        exp_box(mk_box(33'd64, 16'd1, 10'd3, 10'd5, 10'd0, 11'd8, 11'd8, 11'd1, 2'd0));
        exp_box(mk_box(33'd576, 16'd2, 10'd31, 10'd4, 10'd100, 11'd64, 11'd9, 11'd1, 2'd1));
        exp_box(mk_box(33'd65, 16'd3, 10'd33, 10'd0, 10'd0, 11'd65, 11'd1, 11'd1, 2'd2));
        push_rec(mk_rec(16'hABCD, 10'd0, 10'd1023, 10'd0, 10'd1023, 10'd0, 10'd1023), 1'b0);
        push_rec(mk_rec(16'd1, 10'd0, 10'd7, 10'd2, 10'd9, 10'd0, 10'd0), 1'b0);
        push_rec(mk_rec(16'd2, 10'd0, 10'd63, 10'd0, 10'd8, 10'd100, 10'd100), 1'b0);
        push_rec(mk_rec(16'd3, 10'd1, 10'd65, 10'd0, 10'd0, 10'd0, 10'd0), 1'b0);
        drain("t2");

        // Close the frame holding the five boxes so far
        exp_marker();
        push_fd();
        drain("frame5");
        check("frame_box_count_5", bus.frame_box_count, 5);

        // Three boxes then frame_done alone
        exp_box(mk_box(33'd1, 16'd1, 10'd4, 10'd4, 10'd4, 11'd1, 11'd1, 11'd1, 2'd0));
        exp_box(mk_box(33'd8, 16'd2, 10'd0, 10'd0, 10'd0, 11'd2, 11'd2, 11'd2, 2'd0));
        exp_box(mk_box(33'd768, 16'd3, 10'd1011, 10'd500, 10'd7, 11'd24, 11'd2, 11'd16, 2'd1));
        exp_marker();
        push_rec(mk_rec(16'd1, 10'd4, 10'd4, 10'd4, 10'd4, 10'd4, 10'd4), 1'b0);
        push_rec(mk_rec(16'd2, 10'd0, 10'd1, 10'd0, 10'd1, 10'd0, 10'd1), 1'b0);
        push_rec(mk_rec(16'd3, 10'd1000, 10'd1023, 10'd500, 10'd501, 10'd0, 10'd15), 1'b0);
        push_fd();
        drain("frame3");
        check("frame_box_count_3", bus.frame_box_count, 3);

        // Rejected record carrying the frame end becomes a lone marker
        exp_marker();
        push_rec(mk_rec(16'd5, 10'd9, 10'd5, 10'd0, 10'd0, 10'd0, 10'd0), 1'b1);
        drain("reject");
        check("reject_count_1", bus.reject_count, 1);
        check("frame_box_count_0", bus.frame_box_count, 0);

        // Burst with sink stalled: 16 in FIFO plus 4 in the pipeline, the rest dropped
        bus.out_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i < 20) begin
                exp_box(mk_box(33'(i + 1), 16'(i), 10'(i / 2), 10'd0, 10'd0, 11'(i + 1), 11'd1,
                               11'd1, (i + 1 <= 8) ? 2'd0 : 2'd1));
            end
            push_rec(mk_rec(16'(i), 10'd0, 10'(i), 10'd0, 10'd0, 10'd0, 10'd0), 1'b0);
        end
        check("overflow_count_4", bus.overflow_count, 4);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_hold_size", 32'(bus.out_box[80:65]), 0);
        bus.out_ready = 1'b1;
        drain("burst");
        exp_marker();
        push_fd();
        drain("burst_frame");
        check("frame_box_count_20", bus.frame_box_count, 20);

        // Reset with entries queued and a beat presented
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push_rec(mk_rec(16'd7, 10'd1, 10'd2, 10'd1, 10'd2, 10'd1, 10'd2), 1'b0);
        end
        check("pre_rst_out_valid", bus.out_valid, 1);
        rst = 1'b1;
        cycle();
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_frame_box_count", bus.frame_box_count, 0);
        check("mid_rst_overflow_count", bus.overflow_count, 0);
        check("mid_rst_reject_count", bus.reject_count, 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) cycle();
        check("post_rst_out_valid", bus.out_valid, 0);

        exp_box(mk_box(33'd27, 16'd9, 10'd2, 10'd3, 10'd4, 11'd3, 11'd3, 11'd3, 2'd0));
        push_rec(mk_rec(16'd9, 10'd1, 10'd3, 10'd2, 10'd4, 10'd3, 10'd5), 1'b0);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
